fb_rect_writer: RTL and testbench

- Parametrised successor to the fixed framebuffer filler: writes a rectangular region of the frame-buffer RAM through its write port.
- Fills with a selectable pattern (solid, checkerboard, clear) and signals completion.
- Sits between the coprocessor control logic and the VGA frame-buffer dual-port RAM write side.
- Adds a start/busy/done handshake, RAM back-pressure (wr_ready) and rectangle validation.

---
 rtl/fb_pkg.sv | 22 ++
 rtl/fb_pattern_gen.sv | 37 +++
 rtl/fb_rect_writer.sv | 191 +++++++++++++++++++
 tb/tb_fb_rect_writer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions: fill modes, writer FSM states and the
// default geometry also used by the VGA reader.
package fb_pkg;

   localparam int FB_IMG_W  = 64;
   localparam int FB_IMG_H  = 64;
   localparam int FB_ADDR_W = 12;

   typedef enum logic [1:0] {
      FB_SOLID = 2'b00,
      FB_CHECK = 2'b01,
      FB_CLEAR = 2'b10
   } fb_mode_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } fb_state_e;

endpackage

// File: rtl/fb_pattern_gen.sv
// Combinational fill-pattern generator: maps a pixel coordinate, fill mode
// and colour to the pixel value. Mode 11 is treated as solid.
module fb_pattern_gen
   import fb_pkg::*;
#(
   parameter int X_W    = 6,
   parameter int Y_W    = 6,
   parameter int PIX_W  = 1,
   parameter int CHK_SH = 2
) (
   input  logic [X_W-1:0]   x,
   input  logic [Y_W-1:0]   y,
   input  logic [1:0]       mode,
   input  logic [PIX_W-1:0] color,
   output logic [PIX_W-1:0] pixel
);

   localparam int C_W = (X_W > Y_W) ? X_W : Y_W;
   localparam logic [C_W-1:0] CHK_MASK = C_W'(1 << CHK_SH);

   logic [C_W-1:0] xy_s;
   logic           chk_odd_s;

   assign xy_s      = C_W'(x) ^ C_W'(y);
   assign chk_odd_s = |(xy_s & CHK_MASK);

   // pixel value selection per fill mode
   always_comb begin
      pixel = color;
      case (mode)
         FB_CHECK: pixel = chk_odd_s ? ~color : color;
         FB_CLEAR: pixel = {PIX_W{1'b0}};
         default:  pixel = color;
      endcase
   end

endmodule

// File: rtl/fb_rect_writer.sv
// Rectangle filler for the frame-buffer RAM write port with start/busy/done
// handshake and wr_ready back-pressure. Define FB_RECT_COUNT_EN to add pix_count.
module fb_rect_writer
   import fb_pkg::*;
#(
   parameter int IMG_W  = FB_IMG_W,
   parameter int IMG_H  = FB_IMG_H,
   parameter int ADDR_W = FB_ADDR_W,
   parameter int PIX_W  = 1,
   parameter int CHK_SH = 2
) (
   input  logic                       clock_50MHz,
   input  logic                       reset_n,
   input  logic                       start,
   input  logic [1:0]                 mode,
   input  logic [$clog2(IMG_W)-1:0]   x0,
   input  logic [$clog2(IMG_W)-1:0]   x1,
   input  logic [$clog2(IMG_H)-1:0]   y0,
   input  logic [$clog2(IMG_H)-1:0]   y1,
   input  logic [PIX_W-1:0]           color,
   input  logic                       wr_ready,
   output logic [ADDR_W-1:0]          wr_addr,
   output logic [PIX_W-1:0]           wr_data,
   output logic                       wr_en,
   output logic                       busy,
   output logic                       done,
`ifdef FB_RECT_COUNT_EN
   output logic [ADDR_W:0]            pix_count,
`endif
   output logic                       err
);

   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);

   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_CHECK = CHECK;
   localparam logic [1:0] ST_WRITE = WRITE;
   localparam logic [1:0] ST_DONE  = DONE;

   logic [1:0]        state_r;
   logic [XW-1:0]     x0_r, x1_r, x_r;
   logic [YW-1:0]     y0_r, y1_r, y_r;
   logic [1:0]        mode_r;
   logic [PIX_W-1:0]  color_r;

   logic [XW-1:0]     nx_s;
   logic [YW-1:0]     ny_s;
   logic [PIX_W-1:0]  pix_s;
   logic [31:0]       x1_ext_s, y1_ext_s;
   logic              rect_ok_s;
   logic              consume_s;
   logic              last_col_s, last_row_s;
   logic [ADDR_W-1:0] base_addr_s;
   logic [ADDR_W-1:0] row_step_s;

   // Widened bounds keep the range test meaningful for non power-of-two heights.
   assign x1_ext_s    = 32'(x1_r);
   assign y1_ext_s    = 32'(y1_r);
   assign rect_ok_s   = (x0_r <= x1_r) && (y0_r <= y1_r) &&
                        (x1_ext_s < 32'(IMG_W)) && (y1_ext_s < 32'(IMG_H));
   assign consume_s   = (state_r == ST_WRITE) && wr_en && wr_ready;
   assign last_col_s  = (x_r == x1_r);
   assign last_row_s  = (y_r == y1_r);
   assign base_addr_s = (ADDR_W'(y0_r) << XW) + ADDR_W'(x0_r);
   assign row_step_s  = ADDR_W'(IMG_W) - ADDR_W'(x1_r - x0_r);

   // coordinate of the pixel that will be presented after this cycle
   always_comb begin
      nx_s = x_r;
      ny_s = y_r;
      if (state_r == ST_CHECK) begin
         nx_s = x0_r;
         ny_s = y0_r;
      end else if (!last_col_s) begin
         nx_s = x_r + XW'(1);
      end else begin
         nx_s = x0_r;
         ny_s = y_r + YW'(1);
      end
   end

   fb_pattern_gen #(
      .X_W    (XW),
      .Y_W    (YW),
      .PIX_W  (PIX_W),
      .CHK_SH (CHK_SH)
   ) u_pattern (
      .x     (nx_s),
      .y     (ny_s),
      .mode  (mode_r),
      .color (color_r),
      .pixel (pix_s)
   );

   // fill FSM and registered write-port outputs
   always_ff @(posedge clock_50MHz) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
         x0_r    <= {XW{1'b0}};
         x1_r    <= {XW{1'b0}};
         x_r     <= {XW{1'b0}};
         y0_r    <= {YW{1'b0}};
         y1_r    <= {YW{1'b0}};
         y_r     <= {YW{1'b0}};
         mode_r  <= 2'b00;
         color_r <= {PIX_W{1'b0}};
         wr_addr <= {ADDR_W{1'b0}};
         wr_data <= {PIX_W{1'b0}};
         wr_en   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  x0_r    <= x0;
                  x1_r    <= x1;
                  y0_r    <= y0;
                  y1_r    <= y1;
                  mode_r  <= mode;
                  color_r <= color;
                  busy    <= 1'b1;
                  err     <= 1'b0;
                  state_r <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (!rect_ok_s) begin
                  err     <= 1'b1;
                  done    <= 1'b1;
                  state_r <= ST_DONE;
               end else begin
                  x_r     <= x0_r;
                  y_r     <= y0_r;
                  wr_addr <= base_addr_s;
                  wr_data <= pix_s;
                  wr_en   <= 1'b1;
                  state_r <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               if (consume_s) begin
                  if (last_col_s && last_row_s) begin
                     wr_en   <= 1'b0;
                     done    <= 1'b1;
                     state_r <= ST_DONE;
                  end else if (!last_col_s) begin
                     x_r     <= nx_s;
                     wr_addr <= wr_addr + ADDR_W'(1);
                     wr_data <= pix_s;
                  end else begin
                     x_r     <= nx_s;
                     y_r     <= ny_s;
                     wr_addr <= wr_addr + row_step_s;
                     wr_data <= pix_s;
                  end
               end
            end
            ST_DONE: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               wr_en   <= 1'b0;
               done    <= 1'b0;
               busy    <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef FB_RECT_COUNT_EN
   // consumed-write counter, cleared on each accepted start
   always_ff @(posedge clock_50MHz) begin
      if (!reset_n) begin
         pix_count <= {(ADDR_W+1){1'b0}};
      end else if ((state_r == ST_IDLE) && start) begin
         pix_count <= {(ADDR_W+1){1'b0}};
      end else if (consume_s) begin
         pix_count <= pix_count + (ADDR_W+1)'(1);
      end else begin
         pix_count <= pix_count;
      end
   end
`endif

endmodule

// File: tb/tb_fb_rect_writer.sv
// Directed self-checking bench for fb_rect_writer (default 64x64 geometry).
module tb_fb_rect_writer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  mode = 2'b00;
   logic [5:0]  x0 = 6'd0, x1 = 6'd0, y0 = 6'd0, y1 = 6'd0;
   logic        color = 1'b0;
   logic        wr_ready = 1'b1;
   logic [11:0] wr_addr;
   logic        wr_data;
   logic        wr_en, busy, done, err;
`ifdef FB_RECT_COUNT_EN
   logic [12:0] pix_count;
`endif

   int checks = 0;
   int errors = 0;

   logic [11:0] wa_q[$];
   logic        wd_q[$];
   int          hold_viol = 0;
   logic        prev_stall = 1'b0;
   logic [11:0] prev_addr = 12'd0;
   logic        prev_data = 1'b0;

   fb_rect_writer dut (
      .clock_50MHz (clk),
      .reset_n     (reset_n),
      .start       (start),
      .mode        (mode),
      .x0          (x0),
      .x1          (x1),
      .y0          (y0),
      .y1          (y1),
      .color       (color),
      .wr_ready    (wr_ready),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_en       (wr_en),
      .busy        (busy),
      .done        (done),
`ifdef FB_RECT_COUNT_EN
      .pix_count   (pix_count),
`endif
      .err         (err)
   );

   always #10 clk = ~clk;

   // write monitor: records each write consumed at the coming rising edge
   always @(negedge clk) begin
      if (reset_n && wr_en && wr_ready) begin
         wa_q.push_back(wr_addr);
         wd_q.push_back(wr_data);
      end
      if (prev_stall && wr_en && (wr_addr !== prev_addr || wr_data !== prev_data))
         hold_viol++;
      prev_stall = reset_n && wr_en && !wr_ready;
      prev_addr  = wr_addr;
      prev_data  = wr_data;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_done(input int limit, output int n);
      n = 0;
      while (done !== 1'b1 && n < limit) begin
         step();
         n++;
      end
   endtask

   initial begin
      int n;
      int snap;
      int bad;
      int exp_a[10] = '{129, 130, 131, 132, 133, 193, 194, 195, 196, 197};
      logic exp_d[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

      // reset state
      step();
      step();
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_addr", 32'(wr_addr), 32'd0);
      check("rst_data", 32'(wr_data), 32'd0);
      reset_n = 1'b1;
      step();

      // full frame solid
      x0 = 6'd0; x1 = 6'd63; y0 = 6'd0; y1 = 6'd63; mode = 2'b00; color = 1'b1;
      snap = wa_q.size();
      start = 1'b1;
      step();
      start = 1'b0;
      check("ff_busy_c1", 32'(busy), 32'd1);
      check("ff_wren_c1", 32'(wr_en), 32'd0);
      step();
      check("ff_wren_c2", 32'(wr_en), 32'd1);
      check("ff_addr0", 32'(wr_addr), 32'd0);
      wait_done(5000, n);
      check("ff_done_lat", 32'(n), 32'd4096);
      check("ff_wren_done", 32'(wr_en), 32'd0);
      check("ff_count", 32'(wa_q.size() - snap), 32'd4096);
      bad = 0;
      if (wa_q.size() - snap == 4096)
         for (int i = 0; i < 4096; i++)
            if (wa_q[snap+i] !== 12'(i) || wd_q[snap+i] !== 1'b1) bad++;
      check("ff_seq", 32'(bad), 32'd0);
      step();
      check("ff_busy_end", 32'(busy), 32'd0);
      check("ff_done_end", 32'(done), 32'd0);

      // checkerboard sub-rectangle with start pulses while busy
      x0 = 6'd1; x1 = 6'd5; y0 = 6'd2; y1 = 6'd3; mode = 2'b01; color = 1'b1;
      snap = wa_q.size();
      start = 1'b1;
      step();
      check("cb_busy", 32'(busy), 32'd1);
      x0 = 6'd0; x1 = 6'd63; y0 = 6'd0; y1 = 6'd63; mode = 2'b10; color = 1'b0;
      step();
      check("cb_addr0", 32'(wr_addr), 32'd129);
      check("cb_data0", 32'(wr_data), 32'd1);
      wait_done(200, n);
      check("cb_done_lat", 32'(n), 32'd10);
      check("cb_busy_done", 32'(busy), 32'd1);
      step();
      start = 1'b0;
      check("cb_busy_end", 32'(busy), 32'd0);
      check("cb_done_end", 32'(done), 32'd0);
      step();
      check("cb_ignored", 32'(busy), 32'd0);
      check("cb_count", 32'(wa_q.size() - snap), 32'd10);
      bad = 0;
      if (wa_q.size() - snap == 10)
         for (int i = 0; i < 10; i++)
            if (wa_q[snap+i] !== 12'(exp_a[i]) || wd_q[snap+i] !== exp_d[i]) bad++;
      check("cb_seq", 32'(bad), 32'd0);
`ifdef FB_RECT_COUNT_EN
      check("cb_pix_count", 32'(pix_count), 32'd10);
`endif

      // back-pressure on the same rectangle
      x0 = 6'd1; x1 = 6'd5; y0 = 6'd2; y1 = 6'd3; mode = 2'b01; color = 1'b1;
      snap = wa_q.size();
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      n = 0;
      while (done !== 1'b1 && n < 100) begin
         wr_ready = ~wr_ready;
         step();
         n++;
      end
      wr_ready = 1'b1;
      check("bp_done_lat", 32'(n), 32'd20);
      check("bp_count", 32'(wa_q.size() - snap), 32'd10);
      bad = 0;
      if (wa_q.size() - snap == 10)
         for (int i = 0; i < 10; i++)
            if (wa_q[snap+i] !== 12'(exp_a[i]) || wd_q[snap+i] !== exp_d[i]) bad++;
      check("bp_seq", 32'(bad), 32'd0);
      check("bp_hold", 32'(hold_viol), 32'd0);
      step();

      // invalid rectangle
      x0 = 6'd10; x1 = 6'd9; y0 = 6'd0; y1 = 6'd0; mode = 2'b00;
      snap = wa_q.size();
      start = 1'b1;
      step();
      start = 1'b0;
      check("inv_busy", 32'(busy), 32'd1);
      check("inv_done_c1", 32'(done), 32'd0);
      step();
      check("inv_done_c2", 32'(done), 32'd1);
      check("inv_err", 32'(err), 32'd1);
      check("inv_wren", 32'(wr_en), 32'd0);
      step();
      check("inv_done_off", 32'(done), 32'd0);
      check("inv_err_hold", 32'(err), 32'd1);
      check("inv_nowrite", 32'(wa_q.size() - snap), 32'd0);

      // 1x1 valid start clears err
      x0 = 6'd7; x1 = 6'd7; y0 = 6'd3; y1 = 6'd3; color = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      check("one_err_clr", 32'(err), 32'd0);
      wait_done(20, n);
      check("one_done_lat", 32'(n), 32'd2);
      check("one_count", 32'(wa_q.size() - snap), 32'd1);
      if (wa_q.size() - snap == 1)
         check("one_addr", 32'(wa_q[snap]), 32'd199);
      step();

      // reset during a full-frame fill
      x0 = 6'd0; x1 = 6'd63; y0 = 6'd0; y1 = 6'd63; mode = 2'b00; color = 1'b1;
      snap = wa_q.size();
      start = 1'b1;
      step();
      start = 1'b0;
      n = 0;
      while ((wa_q.size() - snap) < 100 && n < 500) begin
         step();
         n++;
      end
      reset_n = 1'b0;
      step();
      check("mr_wren", 32'(wr_en), 32'd0);
      check("mr_busy", 32'(busy), 32'd0);
      check("mr_done", 32'(done), 32'd0);
      reset_n = 1'b1;
      step();
      step();
      check("mr_wren_after", 32'(wr_en), 32'd0);
      check("mr_count", 32'(wa_q.size() - snap), 32'd100);
      x0 = 6'd0; x1 = 6'd0; y0 = 6'd0; y1 = 6'd0;
      start = 1'b1;
      step();
      start = 1'b0;
      check("mr_restart", 32'(busy), 32'd1);
      wait_done(20, n);
      check("mr_restart_done", 32'(n), 32'd2);
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
